fft8_sched: RTL and testbench
=============================

# fft8_sched

Sequencing controller for an 8-point radix-2 decimation-in-time FFT built around one shared combinational `bfly2` butterfly.
- Owns an 8-entry complex Q16.16 sample buffer and accepts a frame over a valid/ready stream.
- Schedules the 12 butterflies (3 stages × 4) through the single `bfly2` instance, writing results back in place.
- Streams the spectrum out in natural order.

## Interface
Parameters:
- `W`, 32: component width; Q16.16 two's complement, fixed.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `in_re`, `in_im`  in  W each  input sample, real and imaginary.
- `out_valid`  out  1  output bin valid.
- `out_ready`  in  1  downstream accepts a bin.
- `out_re`, `out_im`  out  W each  output bin, real and imaginary.
- `bf_a_re`, `bf_a_im`, `bf_b_re`, `bf_b_im`  out  W each  operands to the `bfly2` ports `a`, `ia`, `b`, `ib`.
- `bf_c_re`, `bf_c_im`, `bf_d_re`, `bf_d_im`  in  W each  `bfly2` results `c`, `ic`, `d`, `id`; c = a+b, d = a−b, combinational.
- `tw_idx`  out  2  twiddle exponent k for W8^k of the current butterfly.
- `busy`  out  1  high in RUN.

## Operation
- States:
  - LOAD → RUN after the 8th accepted sample.
  - RUN → UNLOAD after butterfly 11 writeback.
  - UNLOAD → LOAD after the 8th accepted bin.
- LOAD:
  - `in_ready`=1.
  - Sample n is written to buffer address bitrev3(n); e.g. n=1 → addr 4, n=3 → addr 6.
  - Load counter 0..7.
- RUN: two phases per butterfly, ISSUE then WB.
  - Stage s∈{0,1,2}, butterfly j∈{0..3}, h = 1<<s.
  - top = (j>>s)·2h + (j & (h−1)); bot = top+h; `tw_idx` = (j & (h−1)) << (2−s).
  - ISSUE registers buf[top] onto `bf_a_*` and the (optionally twiddled) buf[bot] onto `bf_b_*`, and registers `tw_idx`.
  - WB writes `bf_c_*` → buf[top] and `bf_d_*` → buf[bot].
  - The order is j=0..3 within a stage, then stages 0, 1, 2.
- UNLOAD:
  - `out_valid`=1; `out_re`/`out_im` = buf[m] for m=0..7 in natural order.
  - m advances only on `out_valid && out_ready`.
- Arithmetic: no scaling or saturation; sums wrap modulo 2^32 in the butterfly. The frame is not rescaled.
- Input is ignored outside LOAD, and `in_ready`=0 there. No start pulse: a full load starts RUN.

## Timing
- Reset values:
  - `in_ready`=0 while `rst` is high, 1 from the first cycle after release.
  - `out_valid`=0, `busy`=0, `tw_idx`=0, all `bf_*` outputs 0, counters 0, state LOAD.
  - Buffer contents are not cleared.
- Latency: the 8th sample is accepted at edge E.
  - `busy` is high for cycles E+1..E+24: 12 butterflies × 2 cycles.
  - `out_valid` rises after edge E+25, with `in_ready`=0 throughout.
- Output back-pressure: `out_re`/`out_im` stay stable while `out_valid && !out_ready`.
- Last bin accepted at edge F: `out_valid`=0 and `in_ready`=1 from cycle F+1. A new sample can be accepted on cycle F+1.
- No simultaneous load and unload: a frame is fully drained before the next is accepted.
- Reset mid-RUN or mid-UNLOAD: abort the frame, return to LOAD next cycle; the partial frame is lost.

## Configuration
- `FFT8_TWIDDLE_EN` defined:
  - In ISSUE, `bf_b_*` = buf[bot] × W8^tw_idx, complex Q16.16.
  - 64-bit products, bits [47:16] taken, truncated.
  - Constants: W^0=(0x0001_0000, 0); W^1=(0x0000_B505, 0xFFFF_4AFB); W^2=(0, 0xFFFF_0000); W^3=(0xFFFF_4AFB, 0xFFFF_4AFB).
  - Output is a true DFT.
- Undefined:
  - `bf_b_*` = buf[bot] unmodified; `tw_idx` is still driven for an external multiplier.
  - Timing is identical.

## Structure
- Package `fft8_pkg` holds:
  - width constant `FFT8_W`=32;
  - state encoding (LOAD, RUN, UNLOAD);
  - the four twiddle constants;
  - a `bitrev3` function.
- One sub-module, `fft8_twiddle_mul`: combinational complex Q16.16 multiply, instantiated only under `FFT8_TWIDDLE_EN`.

## Test plan
- Impulse: load x0=(0x0001_0000, 0), others 0, with `out_ready`=1 → 8 bins all (0x0001_0000, 0); `out_valid` first high 25 cycles after the last accept.
- Constant: all 8 samples (0x0001_0000, 0) → bin0=(0x0008_0000, 0), bins 1..7 = (0, 0) in both configurations.
- Twiddle (`FFT8_TWIDDLE_EN`): x1=(0x0001_0000, 0), others 0 → bin2=(0, 0xFFFF_0000), bin1≈(0x0000_B505, 0xFFFF_4AFB) ±1 LSB.
- Schedule monitor: sampling `tw_idx` on the 12 ISSUE cycles gives the sequence 0,0,0,0, 0,2,0,2, 0,1,2,3.
- Back-pressure: hold `out_ready`=0 for 5 cycles at bin3 → bin3 held stable, no bin lost or duplicated; `in_ready` stays 0 until bin7 is accepted.
- Reset at RUN cycle 10 → next cycle `in_ready`=1 and `busy`=0; a fresh impulse frame then produces the correct all-ones spectrum.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT sequencer: width, FSM encoding,
// W8^k twiddle constants (Q16.16) and the 3-bit bit-reversal helper.
package fft8_pkg;

  localparam int unsigned FFT8_W = 32;

  typedef enum logic [1:0] {
    StLoad   = 2'd0,
    StRun    = 2'd1,
    StUnload = 2'd2
  } fft8_state_e;

  // W8^k = exp(-j*2*pi*k/8) in Q16.16
  localparam logic [FFT8_W-1:0] W8_0_RE = 32'h0001_0000;
  localparam logic [FFT8_W-1:0] W8_0_IM = 32'h0000_0000;
  localparam logic [FFT8_W-1:0] W8_1_RE = 32'h0000_B505;
  localparam logic [FFT8_W-1:0] W8_1_IM = 32'hFFFF_4AFB;
  localparam logic [FFT8_W-1:0] W8_2_RE = 32'h0000_0000;
  localparam logic [FFT8_W-1:0] W8_2_IM = 32'hFFFF_0000;
  localparam logic [FFT8_W-1:0] W8_3_RE = 32'hFFFF_4AFB;
  localparam logic [FFT8_W-1:0] W8_3_IM = 32'hFFFF_4AFB;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/fft8_twiddle_mul.sv
// Combinational complex Q16.16 multiply y = x * W8^tw_idx.
// Used by fft8_sched only when FFT8_TWIDDLE_EN is defined.
module fft8_twiddle_mul
  import fft8_pkg::*;
(
  input  logic [FFT8_W-1:0] x_re,
  input  logic [FFT8_W-1:0] x_im,
  input  logic [1:0]        tw_idx,
  output logic [FFT8_W-1:0] y_re,
  output logic [FFT8_W-1:0] y_im
);

  logic        [FFT8_W-1:0]   w_re, w_im;
  logic signed [2*FFT8_W-1:0] xr, xi, wr, wi, acc_re, acc_im;

  // Twiddle constant lookup
  always_comb begin
    w_re = W8_0_RE;
    w_im = W8_0_IM;
    unique case (tw_idx)
      2'd0: begin w_re = W8_0_RE; w_im = W8_0_IM; end
      2'd1: begin w_re = W8_1_RE; w_im = W8_1_IM; end
      2'd2: begin w_re = W8_2_RE; w_im = W8_2_IM; end
      2'd3: begin w_re = W8_3_RE; w_im = W8_3_IM; end
      default: ;
    endcase
  end

  assign xr = {{FFT8_W{x_re[FFT8_W-1]}}, x_re};
  assign xi = {{FFT8_W{x_im[FFT8_W-1]}}, x_im};
  assign wr = {{FFT8_W{w_re[FFT8_W-1]}}, w_re};
  assign wi = {{FFT8_W{w_im[FFT8_W-1]}}, w_im};

  assign acc_re = xr * wr - xi * wi;
  assign acc_im = xr * wi + xi * wr;

  // Keep product bits [47:16]: truncating Q32.32 back to Q16.16
  assign y_re = FFT8_W'(acc_re >>> 16);
  assign y_im = FFT8_W'(acc_im >>> 16);

endmodule

// File: rtl/fft8_sched.sv
// Sequencer for an 8-point radix-2 DIT FFT sharing one external bfly2.
// Loads a frame bit-reversed, runs 12 in-place butterflies (ISSUE/WB),
// then streams bins out in natural order.
// Optional: define FFT8_TWIDDLE_EN to apply W8^k to the bottom operand internally.
module fft8_sched
  import fft8_pkg::*;
#(
  parameter int unsigned W = FFT8_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [W-1:0] bf_a_re,
  output logic [W-1:0] bf_a_im,
  output logic [W-1:0] bf_b_re,
  output logic [W-1:0] bf_b_im,
  input  logic [W-1:0] bf_c_re,
  input  logic [W-1:0] bf_c_im,
  input  logic [W-1:0] bf_d_re,
  input  logic [W-1:0] bf_d_im,
  output logic [1:0]   tw_idx,
  output logic         busy
);

  fft8_state_e state_q;
  logic [W-1:0] mem_re [8];
  logic [W-1:0] mem_im [8];
  logic [2:0]   ld_cnt_q, out_idx_q, out_idx_nx;
  logic [3:0]   bf_idx_q;
  logic         wb_q;
  logic [1:0]   stage, bj, sched_tw;
  logic [2:0]   top, bot;
  logic [W-1:0] bot_re, bot_im, b_re, b_im;
  logic         in_fire;

  // in_ready drops combinationally with rst so nothing is accepted during reset
  assign in_ready   = (state_q == StLoad) && !rst;
  assign in_fire    = in_valid && in_ready;
  assign busy       = (state_q == StRun);
  assign out_idx_nx = out_idx_q + 3'd1;

  assign stage = bf_idx_q[3:2];
  assign bj    = bf_idx_q[1:0];

  // Butterfly addressing: span h = 1 << stage
  always_comb begin
    top      = 3'd0;
    bot      = 3'd0;
    sched_tw = 2'd0;
    case (stage)
      2'd0: begin top = {bj, 1'b0};        bot = {bj, 1'b1};        sched_tw = 2'd0;          end
      2'd1: begin top = {bj[1], 1'b0, bj[0]}; bot = {bj[1], 1'b1, bj[0]}; sched_tw = {bj[0], 1'b0}; end
      2'd2: begin top = {1'b0, bj};        bot = {1'b1, bj};        sched_tw = bj;            end
      default: ;
    endcase
  end

  assign bot_re = mem_re[bot];
  assign bot_im = mem_im[bot];

`ifdef FFT8_TWIDDLE_EN
  fft8_twiddle_mul u_twiddle_mul (
    .x_re   (bot_re),
    .x_im   (bot_im),
    .tw_idx (sched_tw),
    .y_re   (b_re),
    .y_im   (b_im)
  );
`else
  assign b_re = bot_re;
  assign b_im = bot_im;
`endif

  // Sample buffer: bit-reversed load, in-place butterfly writeback (never cleared)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StLoad && in_fire) begin
        mem_re[bitrev3(ld_cnt_q)] <= in_re;
        mem_im[bitrev3(ld_cnt_q)] <= in_im;
      end else if (state_q == StRun && wb_q) begin
        mem_re[top] <= bf_c_re;
        mem_im[top] <= bf_c_im;
        mem_re[bot] <= bf_d_re;
        mem_im[bot] <= bf_d_im;
      end
    end
  end

  // Control FSM with registered butterfly operands and output bin
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      ld_cnt_q  <= 3'd0;
      out_idx_q <= 3'd0;
      bf_idx_q  <= 4'd0;
      wb_q      <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      bf_a_re   <= '0;
      bf_a_im   <= '0;
      bf_b_re   <= '0;
      bf_b_im   <= '0;
      tw_idx    <= 2'd0;
    end else begin
      case (state_q)
        StLoad: begin
          if (in_fire) begin
            ld_cnt_q <= ld_cnt_q + 3'd1;
            if (ld_cnt_q == 3'd7) begin
              state_q  <= StRun;
              bf_idx_q <= 4'd0;
              wb_q     <= 1'b0;
            end
          end
        end
        StRun: begin
          if (!wb_q) begin
            bf_a_re <= mem_re[top];
            bf_a_im <= mem_im[top];
            bf_b_re <= b_re;
            bf_b_im <= b_im;
            tw_idx  <= sched_tw;
            wb_q    <= 1'b1;
          end else begin
            wb_q <= 1'b0;
            if (bf_idx_q == 4'd11) begin
              state_q   <= StUnload;
              bf_idx_q  <= 4'd0;
              out_idx_q <= 3'd0;
              out_valid <= 1'b0;
            end else begin
              bf_idx_q <= bf_idx_q + 4'd1;
            end
          end
        end
        StUnload: begin
          // First UNLOAD cycle prefetches bin 0; afterwards advance per handshake
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_re    <= mem_re[out_idx_q];
            out_im    <= mem_im[out_idx_q];
          end else if (out_ready) begin
            if (out_idx_q == 3'd7) begin
              out_valid <= 1'b0;
              out_idx_q <= 3'd0;
              ld_cnt_q  <= 3'd0;
              state_q   <= StLoad;
            end else begin
              out_idx_q <= out_idx_nx;
              out_re    <= mem_re[out_idx_nx];
              out_im    <= mem_im[out_idx_nx];
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_sched.sv
// Directed bench for fft8_sched with a behavioural bfly2 (c=a+b, d=a-b).
module tb_fft8_sched;
  import fft8_pkg::*;

  localparam int unsigned W = 32;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] in_re, in_im, out_re, out_im;
  logic [W-1:0] bf_a_re, bf_a_im, bf_b_re, bf_b_im;
  logic [W-1:0] bf_c_re, bf_c_im, bf_d_re, bf_d_im;
  logic [1:0]   tw_idx;

  int vectors;
  int miscompares;

  logic [31:0] x_re [8];
  logic [31:0] x_im [8];
  logic [31:0] e_re [8];
  logic [31:0] e_im [8];
  int          tw_exp [12];

  fft8_sched #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .bf_a_re   (bf_a_re),
    .bf_a_im   (bf_a_im),
    .bf_b_re   (bf_b_re),
    .bf_b_im   (bf_b_im),
    .bf_c_re   (bf_c_re),
    .bf_c_im   (bf_c_im),
    .bf_d_re   (bf_d_re),
    .bf_d_im   (bf_d_im),
    .tw_idx    (tw_idx),
    .busy      (busy)
  );

  // Shared butterfly, wrapping modulo 2^32
  assign bf_c_re = bf_a_re + bf_b_re;
  assign bf_c_im = bf_a_im + bf_b_im;
  assign bf_d_re = bf_a_re - bf_b_re;
  assign bf_d_im = bf_a_im - bf_b_im;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_frame();
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_re    = x_re[n];
      in_im    = x_im[n];
      check("in_ready_load", {31'd0, in_ready}, 32'd1);
      step();
    end
    // Keep junk on the input during RUN; it must be ignored
    in_valid = 1'b1;
    in_re    = 32'hDEAD_BEEF;
    in_im    = 32'hCAFE_F00D;
  endtask

  task automatic run_phase();
    for (int i = 0; i < 24; i++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("in_ready_run", {31'd0, in_ready}, 32'd0);
      if (i % 2 == 1) check("tw_idx_seq", {30'd0, tw_idx}, 32'(tw_exp[i / 2]));
      step();
    end
    check("busy_done", {31'd0, busy}, 32'd0);
    check("out_valid_gap", {31'd0, out_valid}, 32'd0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic unload(input bit bp);
    for (int m = 0; m < 8; m++) begin
      if (bp && m == 3) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          check("bp_valid", {31'd0, out_valid}, 32'd1);
          check("bp_hold_re", out_re, e_re[3]);
          check("bp_hold_im", out_im, e_im[3]);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          step();
        end
        out_ready = 1'b1;
      end
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("bin_re", out_re, e_re[m]);
      check("bin_im", out_im, e_im[m]);
      check("in_ready_unload", {31'd0, in_ready}, 32'd0);
      step();
    end
    check("out_valid_end", {31'd0, out_valid}, 32'd0);
    check("in_ready_end", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 8; n++) begin
      x_re[n] = (n == 0) ? 32'h0001_0000 : 32'h0;
      x_im[n] = 32'h0;
      e_re[n] = 32'h0001_0000;
      e_im[n] = 32'h0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tw_exp      = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_re       = '0;
    in_im       = '0;
    out_ready   = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_tw_idx", {30'd0, tw_idx}, 32'd0);
    check("rst_bf_a_re", bf_a_re, 32'd0);
    check("rst_bf_b_im", bf_b_im, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Impulse -> flat spectrum, 25-cycle latency
    set_impulse();
    load_frame();
    run_phase();
    unload(1'b0);

    // Constant -> energy in bin 0 only
    for (int n = 0; n < 8; n++) begin
      x_re[n] = 32'h0001_0000;
      x_im[n] = 32'h0;
      e_re[n] = (n == 0) ? 32'h0008_0000 : 32'h0;
      e_im[n] = 32'h0;
    end
    load_frame();
    run_phase();
    unload(1'b0);

    // Imaginary sample at n=2, with back-pressure on bin 3
    for (int n = 0; n < 8; n++) begin
      x_re[n] = 32'h0;
      x_im[n] = (n == 2) ? 32'h0002_0000 : 32'h0;
    end
`ifdef FFT8_TWIDDLE_EN
    e_re = '{32'h0, 32'h0002_0000, 32'h0, 32'hFFFE_0000,
             32'h0, 32'h0002_0000, 32'h0, 32'hFFFE_0000};
    e_im = '{32'h0002_0000, 32'h0, 32'hFFFE_0000, 32'h0,
             32'h0002_0000, 32'h0, 32'hFFFE_0000, 32'h0};
`else
    e_re = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    e_im = '{32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000, 32'hFFFE_0000,
             32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000, 32'hFFFE_0000};
`endif
    load_frame();
    run_phase();
    unload(1'b1);

    // Reset during RUN cycle 10 aborts the frame
    set_impulse();
    load_frame();
    repeat (9) step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    load_frame();
    run_phase();
    unload(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
